// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scheduler
//  Description : Decode-stage hazard unit for a 5-stage pipeline. Tracks the
//                destinations of instructions in EX/MEM/WB, raises load-use
//                and decode-resolved-branch stalls, selects EX/MEM forwarding
//                for decode Rs, and sequences the HALT drain.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scheduler (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic       id_halt,
    input  logic [2:0] id_rs,
    input  logic [2:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic       id_br_rs,
    input  logic       id_regwrite,
    input  logic [2:0] id_wreg,
    input  logic       id_memread,
    input  logic       mem_stall,
    output logic       stall,
    output logic       XD_fwd,
    output logic       draining,
    output logic       halted
);

    // Scoreboard entry layout: {valid, regwrite, wreg[2:0], memread}
    localparam int         c_E_VALID = 5;
    localparam int         c_E_RW    = 4;
    localparam int         c_E_MR    = 0;

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_DRAIN  = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;

    localparam logic [1:0] c_DRAIN_CYCLES = 2'd3;

    // Index 0 = EX, 1 = MEM, 2 = WB
    logic [5:0] r_sb [3];
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;

    logic [5:0] w_id_entry;
    logic       w_ex_rs;
    logic       w_ex_rt;
    logic       w_mem_rs;
    logic       w_load_use;
    logic       w_br_ex;
    logic       w_br_mem;
    logic       w_hazard;
    logic       w_issue;

    function automatic logic f_match(input logic [5:0] e, input logic [2:0] r);
        return e[c_E_VALID] & e[c_E_RW] & (e[3:1] == r);
    endfunction

    assign w_id_entry = {1'b1, id_regwrite, id_wreg, id_memread};

    assign w_ex_rs  = f_match(r_sb[0], id_rs);
    assign w_ex_rt  = f_match(r_sb[0], id_rt);
    assign w_mem_rs = f_match(r_sb[1], id_rs);

    // A load in EX cannot forward in time for any consumer in decode.
    assign w_load_use = id_valid & r_sb[0][c_E_MR] &
                        ((w_ex_rs & id_rs_used) | (w_ex_rt & id_rt_used));
    // Branch/JR resolve in decode, so an EX producer is always too late.
    assign w_br_ex    = id_valid & id_br_rs & w_ex_rs;
    // MEM producer: ALU results forward, load data is not yet available.
    assign w_br_mem   = id_valid & id_br_rs & ~w_ex_rs & w_mem_rs;

    assign w_hazard = w_load_use | w_br_ex | (w_br_mem & r_sb[1][c_E_MR]);

    assign stall    = w_hazard | mem_stall | (r_state != c_ST_RUN);
    assign XD_fwd   = w_br_mem & ~r_sb[1][c_E_MR] & ~stall;
    assign draining = (r_state == c_ST_DRAIN);
    assign halted   = (r_state == c_ST_HALTED);

    assign w_issue  = id_valid & ~stall & (r_state == c_ST_RUN);

    // Scoreboard shifts one stage per unfrozen cycle; stalls inject bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb[0] <= '0;
            r_sb[1] <= '0;
            r_sb[2] <= '0;
        end else if (!mem_stall) begin
            r_sb[2] <= r_sb[1];
            r_sb[1] <= r_sb[0];
            r_sb[0] <= w_issue ? w_id_entry : 6'd0;
        end
    end

    // Halt sequencer state and drain counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: accept HALT only when it actually issues, then count
    // three unfrozen cycles so it and its predecessors leave the pipe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_RUN: begin
                if (id_valid & id_halt & ~w_hazard & ~mem_stall) begin
                    w_state_nxt = c_ST_DRAIN;
                    w_cnt_nxt   = c_DRAIN_CYCLES;
                end
            end
            c_ST_DRAIN: begin
                if (!mem_stall) begin
                    w_cnt_nxt = r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        w_state_nxt = c_ST_HALTED;
                    end
                end
            end
            c_ST_HALTED: begin
                w_state_nxt = c_ST_HALTED;
            end
            default: begin
                w_state_nxt = c_ST_RUN;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scheduler
//  Description : Self-checking bench for hazard_scheduler. A pipeline-level
//                reference model predicts the outputs every cycle; directed
//                scenarios pin specific literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_halt;
    logic [2:0] id_rs, id_rt;
    logic       id_rs_used, id_rt_used, id_br_rs;
    logic       id_regwrite;
    logic [2:0] id_wreg;
    logic       id_memread;
    logic       mem_stall;
    logic       stall, XD_fwd, draining, halted;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_halt    (id_halt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_br_rs   (id_br_rs),
        .id_regwrite(id_regwrite),
        .id_wreg    (id_wreg),
        .id_memread (id_memread),
        .mem_stall  (mem_stall),
        .stall      (stall),
        .XD_fwd     (XD_fwd),
        .draining   (draining),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        bit       v;
        bit       rw;
        bit [2:0] wr;
        bit       mr;
    } ent_t;

    localparam int c_M_RUN    = 0;
    localparam int c_M_DRAIN  = 1;
    localparam int c_M_HALTED = 2;

    ent_t pipe [3];          // 0 = EX, 1 = MEM, 2 = WB
    int   mode       = c_M_RUN;
    int   drain_left = 0;
    bit   started    = 0;

    // Nearest in-flight stage that will write register r, or -1.
    function automatic int nearest_writer(input bit [2:0] r);
        for (int i = 0; i < 3; i++)
            if (pipe[i].v && pipe[i].rw && pipe[i].wr == r) return i;
        return -1;
    endfunction

    function automatic void model_out(output bit s, output bit f);
        int  rs_src, rt_src;
        bit  haz, fwd;
        rs_src = nearest_writer(id_rs);
        rt_src = nearest_writer(id_rt);
        haz = 0;
        fwd = 0;
        if (id_valid) begin
            if (pipe[0].mr && ((id_rs_used && rs_src == 0) || (id_rt_used && rt_src == 0)))
                haz = 1;
            if (id_br_rs) begin
                if (rs_src == 0) haz = 1;
                else if (rs_src == 1) begin
                    if (pipe[1].mr) haz = 1;
                    else fwd = 1;
                end
            end
        end
        s = haz || mem_stall || (mode != c_M_RUN);
        f = fwd && !s;
    endfunction

    // Model advances on each clock edge from the inputs present at the edge.
    always @(posedge clk) begin
        bit s, f, accept;
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            mode       = c_M_RUN;
            drain_left = 0;
            started    = 1;
        end else if (started && !mem_stall) begin
            model_out(s, f);
            accept  = id_valid && !s;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = accept ? ent_t'{1'b1, id_regwrite, id_wreg, id_memread} : ent_t'(0);
            if (accept && id_halt) begin
                mode       = c_M_DRAIN;
                drain_left = 3;
            end else if (mode == c_M_DRAIN) begin
                drain_left--;
                if (drain_left == 0) mode = c_M_HALTED;
            end
        end
    end

    // Compare process: every cycle, mid-period, DUT against model.
    always @(negedge clk) begin
        bit s, f;
        if (started) begin
            model_out(s, f);
            n_tests += 4;
            if (stall !== s) begin
                n_fail++;
                $display("FAIL model_stall t=%0t dut=%b exp=%b", $time, stall, s);
            end
            if (XD_fwd !== f) begin
                n_fail++;
                $display("FAIL model_xdfwd t=%0t dut=%b exp=%b", $time, XD_fwd, f);
            end
            if (draining !== (mode == c_M_DRAIN)) begin
                n_fail++;
                $display("FAIL model_draining t=%0t dut=%b exp=%b", $time, draining, mode == c_M_DRAIN);
            end
            if (halted !== (mode == c_M_HALTED)) begin
                n_fail++;
                $display("FAIL model_halted t=%0t dut=%b exp=%b", $time, halted, mode == c_M_HALTED);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input bit v, input bit h, input bit [2:0] rs, input bit [2:0] rt,
                         input bit rsu, input bit rtu, input bit br,
                         input bit rw, input bit [2:0] wr, input bit mr);
        id_valid    = v;
        id_halt     = h;
        id_rs       = rs;
        id_rt       = rt;
        id_rs_used  = rsu;
        id_rt_used  = rtu;
        id_br_rs    = br;
        id_regwrite = rw;
        id_wreg     = wr;
        id_memread  = mr;
    endtask

    task automatic bubble();
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t dut=%b exp=%b", name, $time, act, exp);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst       = 1;
        mem_stall = 0;
        bubble();
        step();
        step();
        #5;
        lit("rst_stall",    stall,    1'b0);
        lit("rst_xdfwd",    XD_fwd,   1'b0);
        lit("rst_draining", draining, 1'b0);
        lit("rst_halted",   halted,   1'b0);
        mem_stall = 1;
        #1;
        lit("rst_memstall_stall", stall, 1'b1);

        // Load-use: LD R3 then ADD reading R3
        step(); rst = 0; mem_stall = 0;
        instr(1, 0, 0, 0, 0, 0, 0, 1, 3'd3, 1);
        #5 lit("ld_issue_stall", stall, 1'b0);
        step(); instr(1, 0, 3'd3, 3'd1, 1, 1, 0, 1, 3'd5, 0);
        #5 lit("ld_use_stall", stall, 1'b1);
        step();
        #5 lit("ld_use_release", stall, 1'b0);
        // ADD now in EX: branch on R5 must stall, then forward from MEM
        step(); instr(1, 0, 3'd5, 3'd0, 1, 0, 1, 0, 3'd0, 0);
        #5 lit("add_in_ex_stall", stall, 1'b1);
        lit("add_in_ex_fwd", XD_fwd, 1'b0);
        step();
        #5 lit("add_in_mem_stall", stall, 1'b0);
        lit("add_in_mem_fwd", XD_fwd, 1'b1);
        step(); bubble();

        // ADDI R2 then BEQZ R2
        step(); instr(1, 0, 0, 0, 1, 0, 0, 1, 3'd2, 0);
        #5 lit("addi_stall", stall, 1'b0);
        step(); instr(1, 0, 3'd2, 3'd0, 1, 0, 1, 0, 3'd0, 0);
        #5 lit("beqz_ex_stall", stall, 1'b1);
        lit("beqz_ex_fwd", XD_fwd, 1'b0);
        step();
        #5 lit("beqz_mem_stall", stall, 1'b0);
        lit("beqz_mem_fwd", XD_fwd, 1'b1);
        step(); bubble();

        // LD R4, NOP, JR R4
        step(); instr(1, 0, 0, 0, 0, 0, 0, 1, 3'd4, 1);
        step(); instr(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
        step(); instr(1, 0, 3'd4, 3'd0, 1, 0, 1, 0, 3'd0, 0);
        #5 lit("jr_ldmem_stall", stall, 1'b1);
        lit("jr_ldmem_fwd", XD_fwd, 1'b0);
        step();
        #5 lit("jr_wb_stall", stall, 1'b0);
        lit("jr_wb_fwd", XD_fwd, 1'b0);
        step(); bubble();

        // HALT held off by a load-use hazard, then normal 3-cycle drain
        step(); instr(1, 0, 0, 0, 0, 0, 0, 1, 3'd2, 1);
        step(); instr(1, 1, 3'd2, 3'd0, 1, 0, 0, 0, 3'd0, 0);
        #5 lit("halt_hazard_stall", stall, 1'b1);
        step();
        #5 lit("halt_not_taken", draining, 1'b0);
        lit("halt_clear_stall", stall, 1'b0);
        step(); bubble();
        for (int i = 0; i < 3; i++) begin
            #5 lit("drain_cycle", draining, 1'b1);
            lit("drain_stall", stall, 1'b1);
            step();
        end
        #5 lit("halted_set", halted, 1'b1);
        lit("halted_not_draining", draining, 1'b0);
        step(); step();
        #5 lit("halted_sticky", halted, 1'b1);

        // Reset in DRAIN with counter=2 while memory is busy
        step(); rst = 1;
        step(); rst = 0;
        instr(1, 1, 0, 0, 0, 0, 0, 1, 3'd6, 0);
        #5 lit("halt2_stall", stall, 1'b0);
        step(); bubble();
        step(); rst = 1; mem_stall = 1;
        #5 lit("drain2_before_rst", draining, 1'b1);
        step(); rst = 0; mem_stall = 0;
        instr(1, 0, 3'd6, 3'd0, 1, 0, 1, 0, 3'd0, 0);
        #5 lit("rst_drain_draining", draining, 1'b0);
        lit("rst_drain_halted", halted, 1'b0);
        lit("rst_drain_stall", stall, 1'b0);
        lit("rst_drain_sb_clear", XD_fwd, 1'b0);
        step(); bubble();

        // Drain stretched by two mem_stall cycles
        step(); instr(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0);
        step(); bubble();
        for (int i = 0; i < 5; i++) begin
            mem_stall = (i == 1 || i == 2);
            #5 lit("drain5_cycle", draining, 1'b1);
            step();
        end
        mem_stall = 0;
        #5 lit("drain5_halted", halted, 1'b1);
        step(); rst = 1;
        step(); rst = 0;

        // Randomized traffic checked by the model
        for (int c = 0; c < 4000; c++) begin
            if (mode == c_M_HALTED) rst = ($urandom_range(3) == 0);
            else                    rst = ($urandom_range(79) == 0);
            mem_stall = ($urandom_range(5) == 0);
            instr($urandom_range(7) != 0, $urandom_range(39) == 0,
                  3'($urandom_range(3)), 3'($urandom_range(3)),
                  $urandom_range(1) == 1, $urandom_range(1) == 1,
                  $urandom_range(2) == 0,
                  $urandom_range(3) != 0, 3'($urandom_range(3)),
                  $urandom_range(2) == 0);
            step();
        end

        #5;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 SHALL have port: clk  input  1  system clock; the only clock.
REQ-002 SHALL have port: rst  input  1  master reset; synchronous, active-high.
REQ-003 SHALL have ports: id_valid  input  1  decode slot holds a real instruction; id_halt  input  1  decode instruction is HALT.
REQ-004 SHALL have ports: id_rs, id_rt  input  3 each  decode source registers (Instruction[10:8], [7:5]); id_rs_used, id_rt_used  input  1 each  source actually read.
REQ-005 SHALL have port: id_br_rs  input  1  decode instruction resolves in decode using Rs (branch, JR, JALR).
REQ-006 SHALL have ports: id_regwrite  input  1; id_wreg  input  3; id_memread  input  1  decode instruction's write-back controls.
REQ-007 SHALL have port: mem_stall  input  1  memory busy; freezes the whole pipeline.
REQ-008 SHALL have ports: stall  output  1  hold PC and IF/ID and insert a bubble into ID/EX; XD_fwd  output  1  select EX/MEM ALU result as decode Rs.
REQ-009 SHALL have ports: draining  output  1  halt accepted, pipeline emptying; halted  output  1  pipeline empty after HALT.

Function
REQ-010 SHALL keep a 3-entry scoreboard (EX, MEM, WB), each entry {valid, regwrite, wreg[2:0], memread}.
REQ-011 SHALL advance the scoreboard on every cycle with mem_stall=0: WB<=MEM, MEM<=EX, EX<=decode fields if id_valid & !stall & state RUN, else EX<=bubble (valid=0).
REQ-012 SHALL hold all scoreboard entries unchanged while mem_stall=1.
REQ-013 SHALL define match(E,r) = E.valid & E.regwrite & (E.wreg==r); R0 is an ordinary register (no exemption).
REQ-014 Load-use: SHALL assert stall when id_valid and EX.memread and match(EX, id_rs) with id_rs_used, or match(EX, id_rt) with id_rt_used.
REQ-015 Decode-resolved Rs: when id_valid & id_br_rs, SHALL assert stall if match(EX, id_rs) (any producer in EX).
REQ-016 When id_valid & id_br_rs & !match(EX,id_rs) & match(MEM,id_rs): SHALL assert stall if MEM.memread, else XD_fwd=1 and no stall.
REQ-017 SHALL treat WB-stage matches as no hazard (register-file bypass covers them).
REQ-018 XD_fwd SHALL be 0 whenever stall=1 or id_valid=0; stall and XD_fwd are combinational from current scoreboard and decode inputs.
REQ-019 SHALL assert stall whenever mem_stall=1 or state is DRAIN or HALTED.
REQ-020 FSM states RUN, DRAIN, HALTED; RUN->DRAIN when id_valid & id_halt & !stall & !mem_stall (HALT enters EX that cycle).
REQ-021 On entering DRAIN SHALL load a 2-bit counter with 3; SHALL decrement it on each DRAIN cycle with mem_stall=0; DRAIN->HALTED on the decrement from 1 to 0.
REQ-022 HALTED SHALL be sticky until rst; draining=1 exactly in DRAIN; halted=1 exactly in HALTED.
REQ-023 A HALT that is itself stalled by a hazard SHALL NOT be accepted until the hazard clears.
REQ-024 Simultaneous load-use and branch hazard SHALL produce a single stall; XD_fwd stays 0.

Reset
REQ-025 On rst=1 at a clk edge SHALL clear all scoreboard valid bits, counter=0, state=RUN, regardless of mem_stall or state.
REQ-026 After reset, with rst held high, outputs SHALL be stall=0 (unless mem_stall=1), XD_fwd=0, draining=0, halted=0.
REQ-027 Reset asserted mid-DRAIN or in HALTED SHALL return to RUN the following cycle.

Verification
REQ-028 LD R3 issued, next cycle ADD reads Rs=R3 -> stall=1 for exactly 1 cycle, ADD enters EX the following cycle.
REQ-029 ADDI R2 issued, next cycle BEQZ R2 -> stall=1 one cycle, then XD_fwd=1, stall=0 on the following cycle.
REQ-030 LD R4, then NOP, then JR R4 -> stall=1 one cycle (load in MEM), XD_fwd=0, next cycle no stall (WB bypass).
REQ-031 HALT accepted with mem_stall=0 throughout -> draining=1 for 3 cycles, then halted=1 held until rst.
REQ-032 HALT accepted, mem_stall=1 for 2 cycles during DRAIN -> draining lasts 5 cycles, scoreboard frozen during mem_stall.
REQ-033 rst asserted during DRAIN with counter=2 -> next cycle state RUN, draining=0, all scoreboard entries invalid, stall=0.
